// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared constants and state type for the histogram blocks
package hist_pkg;

  localparam int BIN_COUNT = 256;
  localparam int PIX_W     = 8;
  localparam int BIN_W     = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } hist_state_t;

endpackage

// File: rtl/histogram_rmw.sv
// rtl/histogram_rmw.sv - bin read-modify-write stage with one-deep forwarding and saturation
module histogram_rmw
  import hist_pkg::*;
#(
  parameter int CNT_W = BIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_valid,
  input  logic [PIX_W-1:0] acc_bin,
  input  logic             clr_valid,
  input  logic [PIX_W-1:0] clr_addr,
  input  logic [CNT_W-1:0] q_rd,
  output logic             we,
  output logic [PIX_W-1:0] addr_wr,
  output logic [CNT_W-1:0] data_wr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clr_q;
  logic             fwd_valid;
  logic [PIX_W-1:0] fwd_addr;
  logic [CNT_W-1:0] fwd_val;
  logic [CNT_W-1:0] base;

  // The RAM returns stale data when last cycle's write hit the same bin, so reuse that write.
  assign base = (fwd_valid && (fwd_addr == addr_wr)) ? fwd_val : q_rd;

  always_comb begin
    data_wr = '0;
    if (we && !clr_q) begin
      data_wr = (base == CNT_MAX) ? CNT_MAX : base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we        <= 1'b0;
      clr_q     <= 1'b0;
      addr_wr   <= '0;
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_val   <= '0;
    end else begin
      we    <= acc_valid || clr_valid;
      clr_q <= clr_valid;
      if (clr_valid) begin
        addr_wr <= clr_addr;
      end else if (acc_valid) begin
        addr_wr <= acc_bin;
      end
      fwd_valid <= we && !clr_q;
      fwd_addr  <= addr_wr;
      fwd_val   <= data_wr;
    end
  end

endmodule

// File: rtl/histogram_builder.sv
// rtl/histogram_builder.sv - grey-level histogram: clear, accumulate a frame, then signal done
module histogram_builder #(
  parameter int PIXELS_PER_FRAME = 307200,
  parameter int BIN_W            = hist_pkg::BIN_W
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [7:0]       iPixel,
  input  logic             iPixelValid,
  output logic             oReady,
  output logic [7:0]       oAddrRd,
  input  logic [BIN_W-1:0] iQRd,
  output logic [7:0]       oAddrWr,
  output logic [BIN_W-1:0] oDataWr,
  output logic             oWE,
  output logic             oBusy,
  output logic             oDone
);

  import hist_pkg::*;

  localparam int                PCNT_W   = $clog2(PIXELS_PER_FRAME + 1);
  localparam logic [PCNT_W-1:0] LAST_PIX = PCNT_W'(PIXELS_PER_FRAME - 1);
  localparam logic [PIX_W-1:0]  LAST_BIN = PIX_W'(BIN_COUNT - 1);

  hist_state_t       state;
  logic [PIX_W-1:0]  clr_cnt;
  logic [PCNT_W-1:0] pix_cnt;
  logic              accept;
  logic              clr_valid;
  logic [PIX_W-1:0]  clr_addr;

  assign accept  = oReady && iPixelValid;
  assign oAddrRd = accept ? iPixel : '0;

  // A start always wins: it replaces any pending pixel write with the first clear write.
  always_comb begin
    clr_valid = 1'b0;
    clr_addr  = '0;
    if (iStart) begin
      clr_valid = 1'b1;
    end else if (state == ST_CLEAR && clr_cnt != LAST_BIN) begin
      clr_valid = 1'b1;
      clr_addr  = clr_cnt + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      pix_cnt <= '0;
      oReady  <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (iStart) begin
        state   <= ST_CLEAR;
        clr_cnt <= '0;
        pix_cnt <= '0;
        oReady  <= 1'b0;
        oBusy   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_CLEAR: begin
            if (clr_cnt == LAST_BIN) begin
              state  <= ST_ACCUM;
              oReady <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
          ST_ACCUM: begin
            if (accept) begin
              pix_cnt <= pix_cnt + 1'b1;
              if (pix_cnt == LAST_PIX) begin
                state  <= ST_DRAIN;
                oReady <= 1'b0;
              end
            end
          end
          ST_DRAIN: begin
            state <= ST_DONE;
            oDone <= 1'b1;
          end
          ST_DONE: begin
            state <= ST_IDLE;
            oBusy <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            oReady <= 1'b0;
            oBusy  <= 1'b0;
          end
        endcase
      end
    end
  end

  histogram_rmw #(
    .CNT_W (BIN_W)
  ) u_rmw (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .acc_valid (accept && !iStart),
    .acc_bin   (iPixel),
    .clr_valid (clr_valid),
    .clr_addr  (clr_addr),
    .q_rd      (iQRd),
    .we        (oWE),
    .addr_wr   (oAddrWr),
    .data_wr   (oDataWr)
  );

endmodule

// File: tb/tb_histogram_builder.sv
// tb/tb_histogram_builder.sv - randomized frames checked against a bin-count reference model
module tb_histogram_builder;

  localparam int N   = 16;
  localparam int BW  = 3;
  localparam int SAT = (1 << BW) - 1;

  logic          iClk = 1'b0;
  logic          iRst_n = 1'b0;
  logic          iStart = 1'b0;
  logic          iPixelValid = 1'b0;
  logic [7:0]    iPixel = 8'd0;
  logic          oReady, oWE, oBusy, oDone;
  logic [7:0]    oAddrRd, oAddrWr;
  logic [BW-1:0] iQRd, oDataWr;

  logic [BW-1:0] mem [256];
  int            total = 0;
  int            bad = 0;
  int            exp_hist [256];
  int            accepted = 0;
  logic [7:0]    stim_pix [$];
  bit            stim_val [$];

  always #5 iClk = ~iClk;

  histogram_builder #(
    .PIXELS_PER_FRAME (N),
    .BIN_W            (BW)
  ) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iStart      (iStart),
    .iPixel      (iPixel),
    .iPixelValid (iPixelValid),
    .oReady      (oReady),
    .oAddrRd     (oAddrRd),
    .iQRd        (iQRd),
    .oAddrWr     (oAddrWr),
    .oDataWr     (oDataWr),
    .oWE         (oWE),
    .oBusy       (oBusy),
    .oDone       (oDone)
  );

  // Dual-port RAM: synchronous read, old data on same-address read-during-write.
  always @(posedge iClk) begin
    if (oWE) mem[oAddrWr] <= oDataWr;
    iQRd <= mem[oAddrRd];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_add(input logic [7:0] p);
    if (exp_hist[p] < SAT) exp_hist[p]++;
  endtask

  task automatic pulse_start();
    @(negedge iClk);
    iStart = 1'b1;
    iPixel = 8'($urandom);
    iPixelValid = 1'b0;
  endtask

  task automatic idle_ignore(input int n);
    int ok = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      iStart = 1'b0;
      iPixel = 8'($urandom);
      iPixelValid = 1'b1;
      #1;
      if (!oReady && !oWE && !oBusy && !oDone && oAddrRd == 8'd0) ok++;
    end
    check_eq("idle_ignore", ok, n);
  endtask

  task automatic clear_check();
    int good = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge iClk);
      iStart = 1'b0;
      iPixel = 8'($urandom);
      iPixelValid = 1'b1;
      #1;
      if (oWE && oAddrWr == 8'(k) && oDataWr == '0 && oBusy && !oReady && !oDone && oAddrRd == 8'd0)
        good++;
    end
    check_eq("clear_writes", good, 256);
    for (int b = 0; b < 256; b++) exp_hist[b] = 0;
    accepted = 0;
  endtask

  task automatic accum(input int limit, input bit restart_last);
    int         cyc = 0;
    bit         prev_acc = 1'b0;
    bit         v;
    logic [7:0] p;
    while (accepted < limit && cyc < 4000) begin
      @(negedge iClk);
      check_eq("we_follows_accept", oWE, prev_acc);
      check_eq("ready_in_accum", oReady, 1);
      if (stim_pix.size() > 0) begin
        p = stim_pix.pop_front();
        v = stim_val.pop_front();
      end else begin
        p = 8'($urandom);
        v = ($urandom_range(0, 3) != 0);
      end
      iStart = 1'b0;
      iPixel = p;
      iPixelValid = v;
      prev_acc = v;
      if (v) begin
        accepted++;
        model_add(p);
        if (restart_last && accepted == limit) iStart = 1'b1;
      end
      #1;
      check_eq("addr_rd", oAddrRd, v ? p : 8'd0);
      cyc++;
    end
    if (accepted < limit) check_eq("accum_timeout", accepted, limit);
  endtask

  task automatic finish_frame();
    @(negedge iClk);
    iStart = 1'b0;
    iPixel = 8'($urandom);
    iPixelValid = 1'b1;
    check_eq("drain_ready", oReady, 0);
    check_eq("drain_final_we", oWE, 1);
    check_eq("drain_done", oDone, 0);
    @(negedge iClk);
    iPixelValid = 1'b0;
    check_eq("done_pulse", oDone, 1);
    check_eq("done_we", oWE, 0);
    check_eq("done_busy", oBusy, 1);
    @(negedge iClk);
    check_eq("done_single", oDone, 0);
    check_eq("idle_busy", oBusy, 0);
    for (int b = 0; b < 256; b++) check_eq($sformatf("bin%0d", b), mem[b], exp_hist[b]);
  endtask

  task automatic full_frame();
    pulse_start();
    clear_check();
    accum(N, 1'b0);
    finish_frame();
  endtask

  initial begin
    #12;
    check_eq("reset_outputs", {oReady, oWE, oBusy, oDone, oAddrRd, oAddrWr, oDataWr}, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    idle_ignore(8);

    // Distinct bins back-to-back
    for (int i = 0; i < N; i++) begin stim_pix.push_back(8'(i)); stim_val.push_back(1'b1); end
    full_frame();

    // Repeated bin (forwarding) and a saturating bin
    for (int i = 0; i < 6; i++) begin stim_pix.push_back(8'd42); stim_val.push_back(1'b1); end
    for (int i = 0; i < 10; i++) begin stim_pix.push_back(8'd200); stim_val.push_back(1'b1); end
    full_frame();

    // Gap between same-bin hits
    stim_pix.push_back(8'd5); stim_val.push_back(1'b1);
    stim_pix.push_back(8'd5); stim_val.push_back(1'b1);
    stim_pix.push_back(8'd0); stim_val.push_back(1'b0);
    stim_pix.push_back(8'd5); stim_val.push_back(1'b1);
    stim_pix.push_back(8'd9); stim_val.push_back(1'b1);
    stim_pix.push_back(8'd5); stim_val.push_back(1'b1);
    full_frame();

    // Restart after three pixels
    pulse_start();
    clear_check();
    accum(3, 1'b0);
    pulse_start();
    clear_check();
    accum(N, 1'b0);
    finish_frame();

    // Restart on the same cycle as the final pixel
    pulse_start();
    clear_check();
    accum(N, 1'b1);
    clear_check();
    accum(N, 1'b0);
    finish_frame();

    // Reset during clear
    pulse_start();
    @(negedge iClk);
    iStart = 1'b0;
    repeat (40) @(negedge iClk);
    iPixelValid = 1'b1;
    iRst_n = 1'b0;
    #1;
    check_eq("reset_mid_clear", {oReady, oWE, oBusy, oDone, oAddrRd, oAddrWr, oDataWr}, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    idle_ignore(20);
    full_frame();

    // Random frames, some over a narrow pixel range for collisions
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 30; i++) begin
        stim_pix.push_back(8'($urandom_range(0, (f == 0) ? 255 : 7)));
        stim_val.push_back($urandom_range(0, 2) != 0);
      end
      full_frame();
      stim_pix.delete();
      stim_val.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/histogram_builder.md
HISTOGRAM_BUILDER -- requirements
Module: histogram_builder

Interface
REQ-001 SHALL have parameter PIXELS_PER_FRAME, default 307200, meaning pixels accumulated per frame (640x480).
REQ-002 SHALL have parameter BIN_W, default 20, meaning bin count width; it matches the downstream cumulative-histogram RAM word.
REQ-003 SHALL have port iClk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 SHALL have port iRst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port iStart, input, 1 bit: one-cycle pulse that begins clear then accumulate.
REQ-006 SHALL have port iPixel, input, 8 bits: grey-level pixel, which is also the bin index.
REQ-007 SHALL have port iPixelValid, input, 1 bit: iPixel is valid this cycle.
REQ-008 SHALL have port oReady, output, 1 bit: pixels are accepted this cycle.
REQ-009 SHALL have port oAddrRd, output, 8 bits: histogram RAM read address, port A.
REQ-010 SHALL have port iQRd, input, BIN_W bits: RAM read data, valid the cycle after the address.
REQ-011 SHALL have port oAddrWr, output, 8 bits: histogram RAM write address, port B.
REQ-012 SHALL have port oDataWr, output, BIN_W bits: RAM write data.
REQ-013 SHALL have port oWE, output, 1 bit: RAM write enable.
REQ-014 SHALL have port oBusy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port oDone, output, 1 bit: one-cycle pulse when the histogram is complete; it starts the cumulative-histogram block.

Function
REQ-016 SHALL implement states IDLE, CLEAR, ACCUM, DRAIN and DONE.
REQ-017 In IDLE, iStart SHALL move the block to CLEAR; all other inputs are ignored.
REQ-018 CLEAR SHALL last exactly 256 cycles, writing 0 to addresses 0..255 in ascending order with oWE=1, then move to ACCUM.
REQ-019 oReady SHALL be 1 only in ACCUM; pixels presented outside ACCUM SHALL be dropped and SHALL not be counted.
REQ-020 An accepted pixel (iPixelValid and oReady) at cycle t SHALL drive oAddrRd=iPixel combinationally at t, and SHALL write bin iPixel with oWE=1 at t+1.
REQ-021 Write data at t+1 SHALL be iQRd+1, or forward+1 when the bin equals the bin written at t; forward is the value written at t.
REQ-022 Only one forwarding stage SHALL be used; the RAM returns old data on a same-address read-during-write.
REQ-023 Increment SHALL saturate at 2^BIN_W-1.
REQ-024 An accepted-pixel counter SHALL count accepted pixels; on acceptance of pixel number PIXELS_PER_FRAME, oReady SHALL drop and the state SHALL move to DRAIN.
REQ-025 DRAIN SHALL last 1 cycle, during which the final write completes; the state then moves to DONE.
REQ-026 DONE SHALL assert oDone for 1 cycle, then return to IDLE.
REQ-027 iStart in CLEAR, ACCUM or DRAIN SHALL restart CLEAR at address 0 and zero the pixel counter; an in-flight write is discarded.
REQ-028 iStart in the same cycle as the final pixel SHALL take priority, so the block enters CLEAR and does not pulse oDone.
REQ-029 Gaps in iPixelValid SHALL be allowed, and oWE SHALL be 0 on the cycle following a gap.

Reset
REQ-030 While iRst_n=0, the state SHALL be IDLE and oReady, oWE, oBusy and oDone SHALL be 0.
REQ-031 While iRst_n=0, oAddrRd, oAddrWr, oDataWr, the forwarding register and the pixel counter SHALL be 0.
REQ-032 Reset mid-operation SHALL abandon the frame; RAM contents are undefined until the next CLEAR.

Structure
REQ-033 Package hist_pkg SHALL hold BIN_COUNT=256, PIX_W=8, BIN_W=20 and the state enum; the cumulative-histogram block shares this package.
REQ-034 The read-modify-write pipeline (forwarding, saturation) SHALL be the single sub-module histogram_rmw; the FSM and counters SHALL stay in the top level.

Verification
REQ-035 Stimulus: PIXELS_PER_FRAME=8, pixels 0..7 back-to-back. Required response: bins 0..7=1, all others=0, and oDone exactly 2 cycles after the last accept.
REQ-036 Stimulus: PIXELS_PER_FRAME=6, pixel 42 six times back-to-back. Required response: bin 42=6, which proves forwarding.
REQ-037 Stimulus: pixels 5, 5, gap, 5, 9, 5. Required response: bin 5=4 and bin 9=1.
REQ-038 Stimulus: BIN_W=3 with pixel 200 ten times. Required response: bin 200 saturates at 7.
REQ-039 Stimulus: iStart mid-ACCUM after 3 pixels, then a full frame. Required response: only the second frame's counts are present, and 256 clear writes are observed.
REQ-040 Stimulus: iRst_n low mid-CLEAR. Required response: outputs are 0 immediately, and the block is in IDLE and ignores pixels until iStart.
